// File: rtl/sc_statemachine_scroll_pkg.sv
// Shared definitions for the background-scroll controller: state encodings,
// state width and the speed-to-period helper.
package sc_statemachine_scroll_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      RESET_0     = 3'd0,
      START_0     = 3'd1,
      CHECK_START = 3'd2,
      CHECK_TICK  = 3'd3,
      SENDLOAD    = 3'd4,
      PAUSE       = 3'd5,
      CRASH       = 3'd6,
      LEVELEND    = 3'd7
   } scroll_state_e;

   function automatic int max_speed(input int speed_w);
      return (1 << speed_w) - 1;
   endfunction

   // Speed 0 is slowest: one load every MAX_SPEED+1 ticks.
   function automatic int period_of(input int speed_w, input int speed);
      return max_speed(speed_w) - speed + 1;
   endfunction

endpackage

// File: rtl/sc_statemachine_scroll_if.sv
// Game-side signal bundle of the scroll controller; slave is the controller,
// master is the timer/button/datapath side driving it.
interface sc_statemachine_scroll_if
   import sc_statemachine_scroll_pkg::*;
#(
   parameter int SPEED_W = 2,
   parameter int ROW_W   = 8
) ();

   logic               SC_STATEMACHINESCROLL_startButton_InLow;
   logic               SC_STATEMACHINESCROLL_T0_InLow;
   logic               SC_STATEMACHINESCROLL_pause_InLow;
   logic               SC_STATEMACHINESCROLL_crash_InHigh;
   logic [SPEED_W-1:0] SC_STATEMACHINESCROLL_speed_In;
   logic               SC_STATEMACHINESCROLL_clear_OutLow;
   logic               SC_STATEMACHINESCROLL_load_OutLow;
   logic               SC_STATEMACHINESCROLL_upcount_out;
   logic               SC_STATEMACHINESCROLL_levelDone_out;
   logic [ROW_W-1:0]   SC_STATEMACHINESCROLL_rowCount_out;
   logic [STATE_W-1:0] SC_STATEMACHINESCROLL_state_out;

   modport slave (
      input  SC_STATEMACHINESCROLL_startButton_InLow,
      input  SC_STATEMACHINESCROLL_T0_InLow,
      input  SC_STATEMACHINESCROLL_pause_InLow,
      input  SC_STATEMACHINESCROLL_crash_InHigh,
      input  SC_STATEMACHINESCROLL_speed_In,
      output SC_STATEMACHINESCROLL_clear_OutLow,
      output SC_STATEMACHINESCROLL_load_OutLow,
      output SC_STATEMACHINESCROLL_upcount_out,
      output SC_STATEMACHINESCROLL_levelDone_out,
      output SC_STATEMACHINESCROLL_rowCount_out,
      output SC_STATEMACHINESCROLL_state_out
   );

   modport master (
      output SC_STATEMACHINESCROLL_startButton_InLow,
      output SC_STATEMACHINESCROLL_T0_InLow,
      output SC_STATEMACHINESCROLL_pause_InLow,
      output SC_STATEMACHINESCROLL_crash_InHigh,
      output SC_STATEMACHINESCROLL_speed_In,
      input  SC_STATEMACHINESCROLL_clear_OutLow,
      input  SC_STATEMACHINESCROLL_load_OutLow,
      input  SC_STATEMACHINESCROLL_upcount_out,
      input  SC_STATEMACHINESCROLL_levelDone_out,
      input  SC_STATEMACHINESCROLL_rowCount_out,
      input  SC_STATEMACHINESCROLL_state_out
   );

endinterface

// File: rtl/sc_tick_edge.sv
// Falling-edge detector for the active-low T0 timer tick; a held-low T0
// produces a single one-cycle tick.
module sc_tick_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic t0_n,
   output logic tick
);

   logic t0_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t0_reg <= 1'b1;
      end else begin
         t0_reg <= t0_n;
      end
   end

   assign tick = t0_reg & ~t0_n;

endmodule

// File: rtl/sc_statemachine_scroll.sv
// Background-scroll controller: paces row loads off T0 ticks by speed, counts
// rows to level end, and freezes scrolling on pause or crash.
module sc_statemachine_scroll
   import sc_statemachine_scroll_pkg::*;
#(
   parameter int SPEED_W     = 2,
   parameter int ROW_W       = 8,
   parameter int LEVEL_ROWS  = 200,
   parameter int CRASH_TICKS = 8,
   parameter int TICK_W      = 4
) (
   input  logic SC_STATEMACHINESCROLL_CLOCK_50,
   input  logic SC_STATEMACHINESCROLL_RESET_InLow,
   sc_statemachine_scroll_if.slave bus
);

   localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(LEVEL_ROWS);
   localparam logic [TICK_W-1:0] CRASH_LAST = TICK_W'(CRASH_TICKS - 1);

   logic clk;
   logic rst_n;
   logic tick;
   logic start_n;
   logic pause_n;
   logic crash;

   scroll_state_e     state_reg;
   logic [TICK_W-1:0] tick_cnt_reg;
   logic [TICK_W-1:0] crash_cnt_reg;
   logic [TICK_W-1:0] period_reg;
   logic [TICK_W-1:0] period_next;
   logic [ROW_W-1:0]  row_cnt_reg;
   logic [ROW_W-1:0]  row_cnt_next;

   assign clk     = SC_STATEMACHINESCROLL_CLOCK_50;
   assign rst_n   = SC_STATEMACHINESCROLL_RESET_InLow;
   assign start_n = bus.SC_STATEMACHINESCROLL_startButton_InLow;
   assign pause_n = bus.SC_STATEMACHINESCROLL_pause_InLow;
   assign crash   = bus.SC_STATEMACHINESCROLL_crash_InHigh;

   sc_tick_edge u_tick_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .t0_n  (bus.SC_STATEMACHINESCROLL_T0_InLow),
      .tick  (tick)
   );

   assign period_next  = TICK_W'(period_of(SPEED_W, int'(bus.SC_STATEMACHINESCROLL_speed_In)));
   assign row_cnt_next = (row_cnt_reg == LAST_ROW) ? row_cnt_reg : row_cnt_reg + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= RESET_0;
         tick_cnt_reg  <= '0;
         crash_cnt_reg <= '0;
         row_cnt_reg   <= '0;
         period_reg    <= TICK_W'(max_speed(SPEED_W) + 1);
      end else begin
         case (state_reg)
            RESET_0: state_reg <= START_0;
            START_0: begin
               tick_cnt_reg <= '0;
               row_cnt_reg  <= '0;
               state_reg    <= CHECK_START;
            end
            CHECK_START: begin
               if (!start_n) begin
                  period_reg <= period_next;
                  state_reg  <= CHECK_TICK;
               end
            end
            CHECK_TICK: begin
               if (crash) begin
                  crash_cnt_reg <= '0;
                  state_reg     <= CRASH;
               end else if (!pause_n) begin
                  state_reg <= PAUSE;
               end else if (tick) begin
                  if (tick_cnt_reg == period_reg - 1'b1) begin
                     tick_cnt_reg <= '0;
                     state_reg    <= SENDLOAD;
                  end else begin
                     tick_cnt_reg <= tick_cnt_reg + 1'b1;
                  end
               end
            end
            // Speed is re-sampled here so a change applies from the next period.
            SENDLOAD: begin
               row_cnt_reg <= row_cnt_next;
               period_reg  <= period_next;
               state_reg   <= (row_cnt_next == LAST_ROW) ? LEVELEND : CHECK_TICK;
            end
            PAUSE: begin
               if (crash) begin
                  crash_cnt_reg <= '0;
                  state_reg     <= CRASH;
               end else if (pause_n) begin
                  state_reg <= CHECK_TICK;
               end
            end
            CRASH: begin
               if (crash) begin
                  crash_cnt_reg <= '0;
               end else if (tick) begin
                  if (crash_cnt_reg == CRASH_LAST) begin
                     tick_cnt_reg <= '0;
                     state_reg    <= CHECK_TICK;
                  end else begin
                     crash_cnt_reg <= crash_cnt_reg + 1'b1;
                  end
               end
            end
            LEVELEND: begin
               if (!start_n) begin
                  state_reg <= START_0;
               end
            end
            default: state_reg <= RESET_0;
         endcase
      end
   end

   always_comb begin
      bus.SC_STATEMACHINESCROLL_clear_OutLow  = 1'b1;
      bus.SC_STATEMACHINESCROLL_load_OutLow   = 1'b1;
      bus.SC_STATEMACHINESCROLL_upcount_out   = 1'b0;
      bus.SC_STATEMACHINESCROLL_levelDone_out = 1'b0;
      case (state_reg)
         RESET_0:  bus.SC_STATEMACHINESCROLL_clear_OutLow = 1'b0;
         SENDLOAD: begin
            bus.SC_STATEMACHINESCROLL_load_OutLow = 1'b0;
            bus.SC_STATEMACHINESCROLL_upcount_out = 1'b1;
         end
         LEVELEND: bus.SC_STATEMACHINESCROLL_levelDone_out = 1'b1;
         default:  ;
      endcase
   end

   assign bus.SC_STATEMACHINESCROLL_rowCount_out = row_cnt_reg;
   assign bus.SC_STATEMACHINESCROLL_state_out    = state_reg;

endmodule

// File: tb/tb_sc_statemachine_scroll.sv
// Bench for sc_statemachine_scroll: directed vector table, corner-case
// sequences and a randomized run, all checked against a countdown model.
module tb_sc_statemachine_scroll;

   localparam int SPEED_W     = 2;
   localparam int ROW_W       = 8;
   localparam int LEVEL_ROWS  = 12;
   localparam int CRASH_TICKS = 8;
   localparam int TICK_W      = 4;
   localparam int MAXS        = (1 << SPEED_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   sc_statemachine_scroll_if #(.SPEED_W(SPEED_W), .ROW_W(ROW_W)) bus ();

   sc_statemachine_scroll #(
      .SPEED_W     (SPEED_W),
      .ROW_W       (ROW_W),
      .LEVEL_ROWS  (LEVEL_ROWS),
      .CRASH_TICKS (CRASH_TICKS),
      .TICK_W      (TICK_W)
   ) dut (
      .SC_STATEMACHINESCROLL_CLOCK_50    (clk),
      .SC_STATEMACHINESCROLL_RESET_InLow (rst_n),
      .bus                               (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int loads = 0;

   logic       cur_rst   = 1'b0;
   logic       cur_start = 1'b1;
   logic       cur_t0    = 1'b1;
   logic       cur_pause = 1'b1;
   logic       cur_crash = 1'b0;
   logic [1:0] cur_speed = 2'd0;

   // Model: ticks remaining until the next load and freeze ticks remaining.
   int   m_state  = 0;
   int   m_rows   = 0;
   int   m_per    = MAXS + 1;
   int   m_left   = 0;
   int   m_freeze = 0;
   logic m_t0p    = 1'b1;

   typedef struct {
      logic       start_n;
      logic       t0;
      logic [1:0] speed;
      int         st;
      int         load_n;
      int         row;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic tk;
      if (!cur_rst) begin
         m_state = 0;
         m_rows  = 0;
         m_t0p   = 1'b1;
         return;
      end
      tk    = m_t0p && !cur_t0;
      m_t0p = cur_t0;
      case (m_state)
         0: m_state = 1;
         1: begin
            m_rows  = 0;
            m_state = 2;
         end
         2: if (!cur_start) begin
            m_per   = MAXS - int'(cur_speed) + 1;
            m_left  = m_per;
            m_state = 3;
         end
         3: begin
            if (cur_crash) begin
               m_freeze = CRASH_TICKS;
               m_state  = 6;
            end else if (!cur_pause) begin
               m_state = 5;
            end else if (tk) begin
               m_left--;
               if (m_left == 0) m_state = 4;
            end
         end
         4: begin
            if (m_rows < LEVEL_ROWS) m_rows++;
            m_per   = MAXS - int'(cur_speed) + 1;
            m_left  = m_per;
            m_state = (m_rows == LEVEL_ROWS) ? 7 : 3;
         end
         5: begin
            if (cur_crash) begin
               m_freeze = CRASH_TICKS;
               m_state  = 6;
            end else if (cur_pause) begin
               m_state = 3;
            end
         end
         6: begin
            if (cur_crash) begin
               m_freeze = CRASH_TICKS;
            end else if (tk) begin
               m_freeze--;
               if (m_freeze == 0) begin
                  m_left  = m_per;
                  m_state = 3;
               end
            end
         end
         7: if (!cur_start) m_state = 1;
         default: m_state = 0;
      endcase
   endtask

   // Called at posedge+1: drive inputs, advance model, sample after next edge.
   task automatic cyc();
      rst_n = cur_rst;
      bus.SC_STATEMACHINESCROLL_startButton_InLow = cur_start;
      bus.SC_STATEMACHINESCROLL_T0_InLow          = cur_t0;
      bus.SC_STATEMACHINESCROLL_pause_InLow       = cur_pause;
      bus.SC_STATEMACHINESCROLL_crash_InHigh      = cur_crash;
      bus.SC_STATEMACHINESCROLL_speed_In          = cur_speed;
      model_step();
      @(posedge clk);
      #1;
      chk("state", int'(bus.SC_STATEMACHINESCROLL_state_out), m_state);
      chk("clear_n", int'(bus.SC_STATEMACHINESCROLL_clear_OutLow), int'(m_state != 0));
      chk("load_n", int'(bus.SC_STATEMACHINESCROLL_load_OutLow), int'(m_state != 4));
      chk("upcount", int'(bus.SC_STATEMACHINESCROLL_upcount_out), int'(m_state == 4));
      chk("levelDone", int'(bus.SC_STATEMACHINESCROLL_levelDone_out), int'(m_state == 7));
      chk("rowCount", int'(bus.SC_STATEMACHINESCROLL_rowCount_out), m_rows);
      if (bus.SC_STATEMACHINESCROLL_load_OutLow == 1'b0) loads++;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         cur_t0 = 1'b0;
         cyc();
         cur_t0 = 1'b1;
         cyc();
      end
   endtask

   initial begin
      int l0;
      vt[0]  = '{1'b1, 1'b1, 2'd3, 1, 1, 0};
      vt[1]  = '{1'b1, 1'b1, 2'd3, 2, 1, 0};
      vt[2]  = '{1'b1, 1'b1, 2'd3, 2, 1, 0};
      vt[3]  = '{1'b0, 1'b1, 2'd3, 3, 1, 0};
      vt[4]  = '{1'b1, 1'b0, 2'd3, 4, 0, 0};
      vt[5]  = '{1'b1, 1'b1, 2'd3, 3, 1, 1};
      vt[6]  = '{1'b1, 1'b0, 2'd3, 4, 0, 1};
      vt[7]  = '{1'b1, 1'b0, 2'd3, 3, 1, 2};
      vt[8]  = '{1'b1, 1'b0, 2'd3, 3, 1, 2};
      vt[9]  = '{1'b1, 1'b1, 2'd3, 3, 1, 2};
      vt[10] = '{1'b1, 1'b0, 2'd3, 4, 0, 2};
      vt[11] = '{1'b1, 1'b1, 2'd3, 3, 1, 3};

      // Reset held for 3 cycles, then released.
      @(posedge clk);
      #1;
      cur_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rst_clear_n", int'(bus.SC_STATEMACHINESCROLL_clear_OutLow), 0);
         chk("rst_load_n", int'(bus.SC_STATEMACHINESCROLL_load_OutLow), 1);
      end
      cur_rst = 1'b1;
      rst_n   = 1'b1;
      #1;
      chk("rel_state", int'(bus.SC_STATEMACHINESCROLL_state_out), 0);
      chk("rel_clear_n", int'(bus.SC_STATEMACHINESCROLL_clear_OutLow), 0);
      $display("reset: state=%0d clear_n=%0d", bus.SC_STATEMACHINESCROLL_state_out,
               bus.SC_STATEMACHINESCROLL_clear_OutLow);

      foreach (vt[i]) begin
         cur_start = vt[i].start_n;
         cur_t0    = vt[i].t0;
         cur_speed = vt[i].speed;
         cyc();
         chk("vec_state", int'(bus.SC_STATEMACHINESCROLL_state_out), vt[i].st);
         chk("vec_load_n", int'(bus.SC_STATEMACHINESCROLL_load_OutLow), vt[i].load_n);
         chk("vec_upcount", int'(bus.SC_STATEMACHINESCROLL_upcount_out), int'(vt[i].load_n == 0));
         chk("vec_row", int'(bus.SC_STATEMACHINESCROLL_rowCount_out), vt[i].row);
         $display("vec %0d: state=%0d load_n=%0d row=%0d", i,
                  bus.SC_STATEMACHINESCROLL_state_out, bus.SC_STATEMACHINESCROLL_load_OutLow,
                  bus.SC_STATEMACHINESCROLL_rowCount_out);
      end
      cur_start = 1'b1;
      cur_t0    = 1'b1;

      // Speed 0 gives 4-tick periods; a mid-period change applies next period.
      cur_speed = 2'd0;
      tick(1);
      l0 = loads;
      tick(3);
      chk("spd0_3ticks", loads, l0);
      tick(1);
      chk("spd0_4ticks", loads, l0 + 1);
      tick(2);
      cur_speed = 2'd2;
      tick(2);
      chk("spd_chg_cur", loads, l0 + 2);
      tick(1);
      chk("spd_chg_next1", loads, l0 + 2);
      tick(1);
      chk("spd_chg_next2", loads, l0 + 3);
      $display("speed: loads=%0d row=%0d", loads, bus.SC_STATEMACHINESCROLL_rowCount_out);

      // Pause after 2 of 4 ticks; 10 ticks ignored; load 2 ticks after release.
      cur_speed = 2'd0;
      tick(2);
      l0 = loads;
      tick(2);
      cur_pause = 1'b0;
      cyc();
      tick(10);
      chk("pause_noload", loads, l0);
      chk("pause_state", int'(bus.SC_STATEMACHINESCROLL_state_out), 5);
      cur_pause = 1'b1;
      cyc();
      tick(1);
      chk("pause_rel1", loads, l0);
      tick(1);
      chk("pause_rel2", loads, l0 + 1);
      $display("pause: loads=%0d", loads);

      // Crash coincident with a tick, then a re-crash at freeze tick 5.
      l0 = loads;
      cur_crash = 1'b1;
      cur_t0    = 1'b0;
      cyc();
      cur_crash = 1'b0;
      cur_t0    = 1'b1;
      cyc();
      chk("crash_state", int'(bus.SC_STATEMACHINESCROLL_state_out), 6);
      tick(7);
      chk("crash_7", int'(bus.SC_STATEMACHINESCROLL_state_out), 6);
      tick(1);
      chk("crash_8", int'(bus.SC_STATEMACHINESCROLL_state_out), 3);
      chk("crash_noload", loads, l0);
      cur_crash = 1'b1;
      cyc();
      cur_crash = 1'b0;
      tick(5);
      cur_crash = 1'b1;
      cyc();
      cur_crash = 1'b0;
      cur_pause = 1'b0;
      tick(7);
      chk("recrash_7", int'(bus.SC_STATEMACHINESCROLL_state_out), 6);
      cur_pause = 1'b1;
      tick(1);
      chk("recrash_8", int'(bus.SC_STATEMACHINESCROLL_state_out), 3);
      tick(4);
      chk("crash_resume", loads, l0 + 1);
      $display("crash: loads=%0d", loads);

      // Run to level end, confirm freeze, then restart.
      for (int i = 0; i < 100; i++) begin
         if (bus.SC_STATEMACHINESCROLL_levelDone_out == 1'b1) break;
         tick(1);
      end
      chk("lvl_done", int'(bus.SC_STATEMACHINESCROLL_levelDone_out), 1);
      chk("lvl_rows", int'(bus.SC_STATEMACHINESCROLL_rowCount_out), LEVEL_ROWS);
      l0 = loads;
      tick(8);
      chk("lvl_noload", loads, l0);
      cur_start = 1'b0;
      cur_speed = 2'd3;
      cyc();
      cyc();
      cyc();
      cur_start = 1'b1;
      chk("lvl_restart_state", int'(bus.SC_STATEMACHINESCROLL_state_out), 3);
      chk("lvl_restart_row", int'(bus.SC_STATEMACHINESCROLL_rowCount_out), 0);
      tick(1);
      chk("lvl_resume", loads, l0 + 1);
      $display("level: loads=%0d row=%0d", loads, bus.SC_STATEMACHINESCROLL_rowCount_out);

      // Async reset in the middle of a load strobe.
      cur_t0 = 1'b0;
      cyc();
      chk("sl_state", int'(bus.SC_STATEMACHINESCROLL_state_out), 4);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_load_n", int'(bus.SC_STATEMACHINESCROLL_load_OutLow), 1);
      chk("arst_state", int'(bus.SC_STATEMACHINESCROLL_state_out), 0);
      chk("arst_clear_n", int'(bus.SC_STATEMACHINESCROLL_clear_OutLow), 0);
      cur_rst = 1'b0;
      cur_t0  = 1'b1;
      cyc();
      cyc();
      cur_rst = 1'b1;
      cyc();
      $display("async reset: load_n=%0d state=%0d", bus.SC_STATEMACHINESCROLL_load_OutLow,
               bus.SC_STATEMACHINESCROLL_state_out);

      // Randomized run against the model.
      l0 = loads;
      for (int i = 0; i < 4000; i++) begin
         cur_rst   = ($urandom_range(0, 599) != 0);
         cur_t0    = 1'($urandom_range(0, 1));
         cur_start = ($urandom_range(0, 7) != 0);
         cur_crash = ($urandom_range(0, 59) == 0);
         if (cur_pause) cur_pause = ($urandom_range(0, 39) != 0);
         else           cur_pause = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 49) == 0) cur_speed = 2'($urandom_range(0, MAXS));
         cyc();
      end
      $display("random: cycles=4000 loads=%0d", loads - l0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
